// File: rtl/smg_pkg.sv
// rtl/smg_pkg.sv - shared types and seven-segment constants for smg_encode
package smg_pkg;

  typedef enum logic [1:0] {IDLE, CONV, LOAD} smg_state_t;

  localparam logic [7:0] SEG_0   = 8'hC0;
  localparam logic [7:0] SEG_1   = 8'hF9;
  localparam logic [7:0] SEG_2   = 8'hA4;
  localparam logic [7:0] SEG_3   = 8'hB0;
  localparam logic [7:0] SEG_4   = 8'h99;
  localparam logic [7:0] SEG_5   = 8'h92;
  localparam logic [7:0] SEG_6   = 8'h82;
  localparam logic [7:0] SEG_7   = 8'hF8;
  localparam logic [7:0] SEG_8   = 8'h80;
  localparam logic [7:0] SEG_9   = 8'h90;
  localparam logic [7:0] SEG_OFF = 8'hFF;

  localparam logic [3:0] SCAN_THOU = 4'b0111;
  localparam logic [3:0] SCAN_HUND = 4'b1011;
  localparam logic [3:0] SCAN_TENS = 4'b1101;
  localparam logic [3:0] SCAN_ONES = 4'b1110;

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = SEG_0;
      4'd1:    seg_code = SEG_1;
      4'd2:    seg_code = SEG_2;
      4'd3:    seg_code = SEG_3;
      4'd4:    seg_code = SEG_4;
      4'd5:    seg_code = SEG_5;
      4'd6:    seg_code = SEG_6;
      4'd7:    seg_code = SEG_7;
      4'd8:    seg_code = SEG_8;
      4'd9:    seg_code = SEG_9;
      default: seg_code = SEG_OFF;
    endcase
  endfunction

endpackage

// File: rtl/smg_bin2bcd.sv
// rtl/smg_bin2bcd.sv - iterative shift-add-3 binary to 4-digit BCD converter
module smg_bin2bcd #(
  parameter int W = 14
) (
  input  logic         CLK,
  input  logic         RSTn,
  input  logic         start,
  input  logic [W-1:0] bin,
  output logic         done,
  output logic [15:0]  bcd
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  sh;
  logic [CW-1:0] cnt;
  logic [15:0]   adj;

  always_comb begin
    adj = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // done flags the cycle whose closing edge performs the final shift
  assign done = (cnt == CW'(1));

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      sh  <= '0;
      cnt <= '0;
      bcd <= '0;
    end else if (start) begin
      sh  <= bin;
      cnt <= CW'(W);
      bcd <= '0;
    end else if (cnt != '0) begin
      {bcd, sh} <= {adj, sh} << 1;
      cnt       <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/smg_encode.sv
// rtl/smg_encode.sv - binary to seven-segment encoder; SMG_LEAD_BLANK_EN blanks leading zeros
module smg_encode
  import smg_pkg::*;
#(
  parameter int DATA_W         = 14,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic [DATA_W-1:0] In_Data,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [3:0]        ScanSig,
  output logic [7:0]        SmgData,
  output logic              Ovf
);

  // compare at no less than 14 bits so clamping is independent of DATA_W
  localparam int              CW      = (DATA_W > 14) ? DATA_W : 14;
  localparam logic [CW-1:0]   MAX_VAL = CW'(9999);
  localparam logic [7:0]      POL     = SEG_ACTIVE_LOW ? 8'h00 : 8'hFF;

  smg_state_t        state;
  logic              accept;
  logic              over;
  logic              conv_done;
  logic [CW-1:0]     in_ext;
  logic [DATA_W-1:0] conv_in;
  logic [15:0]       bcd;
  logic [15:0]       disp;
  logic [2:0]        blank;
  logic [7:0]        seg_nxt;

  assign accept  = In_Valid && In_Ready;
  assign in_ext  = CW'(In_Data);
  assign over    = (in_ext > MAX_VAL);
  assign conv_in = over ? DATA_W'(MAX_VAL) : In_Data;

  smg_bin2bcd #(.W(DATA_W)) u_bin2bcd (
    .CLK   (CLK),
    .RSTn  (RSTn),
    .start (accept),
    .bin   (conv_in),
    .done  (conv_done),
    .bcd   (bcd)
  );

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state    <= IDLE;
      In_Ready <= 1'b1;
      Ovf      <= 1'b0;
      disp     <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          state    <= CONV;
          In_Ready <= 1'b0;
          Ovf      <= over;
        end
        CONV: if (conv_done) state <= LOAD;
        LOAD: begin
          disp     <= bcd;
          state    <= IDLE;
          In_Ready <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          In_Ready <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
`ifdef SMG_LEAD_BLANK_EN
    blank[2] = (disp[15:12] == 4'd0);
    blank[1] = blank[2] && (disp[11:8] == 4'd0);
    blank[0] = blank[1] && (disp[7:4] == 4'd0);
`else
    blank = 3'b000;
`endif
  end

  always_comb begin
    seg_nxt = SEG_OFF;
    case (ScanSig)
      SCAN_THOU: seg_nxt = blank[2] ? SEG_OFF : seg_code(disp[15:12]);
      SCAN_HUND: seg_nxt = blank[1] ? SEG_OFF : seg_code(disp[11:8]);
      SCAN_TENS: seg_nxt = blank[0] ? SEG_OFF : seg_code(disp[7:4]);
      SCAN_ONES: begin
        seg_nxt = seg_code(disp[3:0]);
        if (Ovf) seg_nxt[7] = 1'b0;
      end
      default: seg_nxt = SEG_OFF;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) SmgData <= SEG_OFF ^ POL;
    else       SmgData <= seg_nxt ^ POL;
  end

endmodule

// File: tb/tb_smg_encode.sv
// tb/tb_smg_encode.sv - directed self-checking bench for smg_encode
module tb_smg_encode;

  localparam int DATA_W = 14;
`ifdef SMG_LEAD_BLANK_EN
  localparam logic [7:0] LZ = 8'hFF;
`else
  localparam logic [7:0] LZ = 8'hC0;
`endif

  logic              CLK = 1'b0;
  logic              RSTn = 1'b0;
  logic [DATA_W-1:0] In_Data = '0;
  logic              In_Valid = 1'b0;
  logic              In_Ready;
  logic [3:0]        ScanSig = 4'b1111;
  logic [7:0]        SmgData;
  logic              Ovf;
  int                checks = 0;
  int                failures = 0;
  int                n;

  always #5 CLK = ~CLK;

  smg_encode #(.DATA_W(DATA_W), .SEG_ACTIVE_LOW(1'b1)) dut (
    .CLK      (CLK),
    .RSTn     (RSTn),
    .In_Data  (In_Data),
    .In_Valid (In_Valid),
    .In_Ready (In_Ready),
    .ScanSig  (ScanSig),
    .SmgData  (SmgData),
    .Ovf      (Ovf)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic scan_check(input logic [3:0] scan, input logic [7:0] exp, input string tag);
    ScanSig = scan;
    tick();
    check(tag, 32'(SmgData), 32'(exp));
  endtask

  task automatic send(input logic [DATA_W-1:0] v);
    In_Data  = v;
    In_Valid = 1'b1;
    tick();
    In_Valid = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int k = 0;
    while (!In_Ready && k < 50) begin
      tick();
      k++;
    end
    check(tag, 32'(In_Ready), 32'd1);
  endtask

  initial begin
    tick();
    tick();
    check("rst_ready", 32'(In_Ready), 32'd1);
    check("rst_ovf", 32'(Ovf), 32'd0);
    check("rst_smg", 32'(SmgData), 32'hFF);
    RSTn = 1'b1;

    // accept on the first edge after reset release
    send(14'd1234);
    n = 0;
    while (!In_Ready && n < 50) begin
      n++;
      tick();
    end
    check("busy_1234", 32'(n), 32'(DATA_W + 1));
    scan_check(4'b0111, 8'hF9, "d1234_thou");
    ScanSig = 4'b1011;
    check("d1234_lat", 32'(SmgData), 32'hF9);
    tick();
    check("d1234_hund", 32'(SmgData), 32'hA4);
    scan_check(4'b1101, 8'hB0, "d1234_tens");
    scan_check(4'b1110, 8'h99, "d1234_ones");
    scan_check(4'b1111, 8'hFF, "d1234_off");

    send(14'd12000);
    check("ovf_set", 32'(Ovf), 32'd1);
    check("ovf_busy", 32'(In_Ready), 32'd0);
    scan_check(4'b0111, 8'hF9, "old_disp_thou");
    wait_ready("ovf_done");
    scan_check(4'b0111, 8'h90, "ovf_thou");
    scan_check(4'b1011, 8'h90, "ovf_hund");
    scan_check(4'b1101, 8'h90, "ovf_tens");
    scan_check(4'b1110, 8'h10, "ovf_ones_dp");

    send(14'd5);
    check("ovf_clr", 32'(Ovf), 32'd0);
    wait_ready("d5_done");
    scan_check(4'b0111, LZ, "d5_thou");
    scan_check(4'b1101, LZ, "d5_tens");
    scan_check(4'b1110, 8'h92, "d5_ones");

    send(14'd7);
    wait_ready("d7_done");
    scan_check(4'b0111, LZ, "d7_thou");
    scan_check(4'b1011, LZ, "d7_hund");
    scan_check(4'b1101, LZ, "d7_tens");
    scan_check(4'b1110, 8'hF8, "d7_ones");

    // In_Valid held high while the block is busy
    In_Data  = 14'd4321;
    In_Valid = 1'b1;
    tick();
    In_Data = 14'd1111;
    n = 0;
    while (!In_Ready && n < 50) begin
      n++;
      tick();
    end
    In_Valid = 1'b0;
    check("busy_4321", 32'(n), 32'(DATA_W + 1));
    scan_check(4'b0111, 8'h99, "d4321_thou");
    scan_check(4'b1011, 8'hB0, "d4321_hund");
    scan_check(4'b1101, 8'hA4, "d4321_tens");
    scan_check(4'b1110, 8'hF9, "d4321_ones");
    check("d4321_ready", 32'(In_Ready), 32'd1);

    // reset in the middle of a conversion
    send(14'd8888);
    tick();
    tick();
    tick();
    RSTn = 1'b0;
    #2;
    check("mid_rst_ready", 32'(In_Ready), 32'd1);
    check("mid_rst_ovf", 32'(Ovf), 32'd0);
    check("mid_rst_smg", 32'(SmgData), 32'hFF);
    tick();
    RSTn = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    check("post_rst_ready", 32'(In_Ready), 32'd1);
    scan_check(4'b0111, LZ, "post_rst_thou");
    scan_check(4'b1110, 8'hC0, "post_rst_ones");
    scan_check(4'b1000, 8'hFF, "post_rst_bad_scan");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
